fp_norm_pack: RTL and testbench



---
 rtl/fp_norm_pack.sv | 165 ++++++++++++++++
 tb/tb_fp_norm_pack.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_pack.sv
// rtl/fp_norm_pack.sv - IEEE754 single add/sub back end: iterative renormaliser and packer (option: FP_NORM_ROUND_NEAREST_EN)
module fp_norm_pack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FRAC_W+1:0]       sum,
    input  logic                    sign_in,
    input  logic [EXP_W-1:0]        exp_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    flag_zero,
    output logic                    flag_ovf,
    output logic                    flag_denorm
);
    localparam int MW = FRAC_W + 2;
    localparam logic [EXP_W-1:0] E_MAX    = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] E_MAX_M1 = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EXP_W-1:0] E_ONE    = {{(EXP_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t                  r_state;
    logic [MW-1:0]           r_mant;
    logic [EXP_W-1:0]        r_e;
    logic                    r_s;
    logic                    r_fz;
    logic                    r_fo;
    logic                    r_fd;
    logic                    r_out_valid;
    logic [EXP_W+FRAC_W:0]   r_result;
    logic                    r_flag_zero;
    logic                    r_flag_ovf;
    logic                    r_flag_denorm;

    logic [MW-1:0]           w_shr;
`ifdef FP_NORM_ROUND_NEAREST_EN
    logic                    r_rnd_inh;
    logic                    w_guard;
    logic [MW-1:0]           w_rnd;
`endif

    // Carry-out correction: one-bit right shift of the working mantissa
    assign w_shr = r_mant >> 1;
`ifdef FP_NORM_ROUND_NEAREST_EN
    // Guard bit lost by the right shift and the rounded-up candidate
    assign w_guard = r_mant[0];
    assign w_rnd   = w_shr + {{(MW-1){1'b0}}, 1'b1};
`endif

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign flag_zero   = r_flag_zero;
    assign flag_ovf    = r_flag_ovf;
    assign flag_denorm = r_flag_denorm;

    // Control FSM: latch operand, normalise one rule per cycle, hold packed result until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_mant        <= '0;
            r_e           <= '0;
            r_s           <= 1'b0;
            r_fz          <= 1'b0;
            r_fo          <= 1'b0;
            r_fd          <= 1'b0;
            r_out_valid   <= 1'b0;
            r_result      <= '0;
            r_flag_zero   <= 1'b0;
            r_flag_ovf    <= 1'b0;
            r_flag_denorm <= 1'b0;
`ifdef FP_NORM_ROUND_NEAREST_EN
            r_rnd_inh     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mant  <= sum;
                        r_e     <= exp_in;
                        r_s     <= sign_in;
                        r_fz    <= 1'b0;
                        r_fo    <= 1'b0;
                        r_fd    <= 1'b0;
`ifdef FP_NORM_ROUND_NEAREST_EN
                        r_rnd_inh <= 1'b0;
`endif
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    if (r_e == E_MAX) begin
                        // inf/NaN operand: pass through untouched
                        r_state <= DONE;
                    end else if (r_mant == '0) begin
                        // exact cancellation; sign is retained so -0 can appear
                        r_e     <= '0;
                        r_fz    <= 1'b1;
                        r_state <= DONE;
                    end else if (r_mant[MW-1]) begin
                        if (r_e >= E_MAX_M1) begin
                            r_e     <= E_MAX;
                            r_mant  <= '0;
                            r_fo    <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_e <= r_e + E_ONE;
`ifdef FP_NORM_ROUND_NEAREST_EN
                            if (!r_rnd_inh && w_guard && w_shr[0]) begin
                                r_mant <= w_rnd;
                                // a rounding carry needs one more pass through this rule, unrounded
                                if (w_rnd[MW-1]) begin
                                    r_rnd_inh <= 1'b1;
                                end else begin
                                    r_state <= DONE;
                                end
                            end else begin
                                r_mant  <= w_shr;
                                r_state <= DONE;
                            end
`else
                            r_mant  <= w_shr;
                            r_state <= DONE;
`endif
                        end
                    end else if (r_mant[MW-2]) begin
                        // subnormal inputs whose sum reached the hidden bit become normal
                        if (r_e == '0) begin
                            r_e <= E_ONE;
                        end
                        r_state <= DONE;
                    end else if (r_e <= E_ONE) begin
                        r_e     <= '0;
                        r_fd    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_mant <= r_mant << 1;
                        r_e    <= r_e - E_ONE;
                    end
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_result      <= {r_s, r_e, r_mant[FRAC_W-1:0]};
                        r_flag_zero   <= r_fz;
                        r_flag_ovf    <= r_fo;
                        r_flag_denorm <= r_fd;
                        r_out_valid   <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid   <= 1'b0;
                        r_flag_zero   <= 1'b0;
                        r_flag_ovf    <= 1'b0;
                        r_flag_denorm <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_norm_pack.sv
// tb/tb_fp_norm_pack.sv - directed self-checking bench for fp_norm_pack
module tb_fp_norm_pack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] sum = '0;
    logic        sign_in = 1'b0;
    logic [7:0]  exp_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        flag_zero;
    logic        flag_ovf;
    logic        flag_denorm;

    int n_vec = 0;
    int n_err = 0;

    fp_norm_pack dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .sign_in(sign_in), .exp_in(exp_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_zero(flag_zero), .flag_ovf(flag_ovf), .flag_denorm(flag_denorm)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [24:0] s, input logic [7:0] e, input logic sg, output int lat);
        @(posedge clk); #1;
        sum = s; exp_in = e; sign_in = sg; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 00000000", result); end
        n_vec++; if ({flag_zero, flag_ovf, flag_denorm} !== 3'b000) begin n_err++;
            $display("FAIL reset_flags got %b want 000", {flag_zero, flag_ovf, flag_denorm}); end
        rst = 1'b0;
    endtask

    task automatic test_unity();
        int lat;
        run_op(25'h0800000, 8'd127, 1'b0, lat);
        n_vec++; if (result !== 32'h3F800000) begin n_err++; $display("FAIL unity_result got %h want 3f800000", result); end
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL unity_latency got %0d want 2", lat); end
        n_vec++; if ({flag_zero, flag_ovf, flag_denorm} !== 3'b000) begin n_err++;
            $display("FAIL unity_flags got %b want 000", {flag_zero, flag_ovf, flag_denorm}); end
        consume();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL unity_release got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL unity_idle got %b want 1", in_ready); end
    endtask

    task automatic test_carry_hold();
        int lat;
        run_op(25'h1000000, 8'd127, 1'b0, lat);
        n_vec++; if (result !== 32'h40000000) begin n_err++; $display("FAIL carry_result got %h want 40000000", result); end
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL carry_latency got %0d want 2", lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_vec++; if (out_valid !== 1'b1 || result !== 32'h40000000 || in_ready !== 1'b0) begin n_err++;
                $display("FAIL hold_cycle%0d got v=%b r=%h rdy=%b want v=1 r=40000000 rdy=0", i, out_valid, result, in_ready); end
        end
        consume();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release got %b want 0", out_valid); end
    endtask

    task automatic test_worst();
        int lat;
        run_op(25'h0000001, 8'd127, 1'b0, lat);
        n_vec++; if (result !== 32'h34000000) begin n_err++; $display("FAIL worst_result got %h want 34000000", result); end
        n_vec++; if (lat !== 25) begin n_err++; $display("FAIL worst_latency got %0d want 25", lat); end
        consume();
    endtask

    task automatic test_denorm();
        int lat;
        run_op(25'h0000100, 8'd3, 1'b0, lat);
        n_vec++; if (result !== 32'h00000400) begin n_err++; $display("FAIL denorm_result got %h want 00000400", result); end
        n_vec++; if ({flag_zero, flag_ovf, flag_denorm} !== 3'b001) begin n_err++;
            $display("FAIL denorm_flags got %b want 001", {flag_zero, flag_ovf, flag_denorm}); end
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL denorm_latency got %0d want 4", lat); end
        consume();
        n_vec++; if (flag_denorm !== 1'b0) begin n_err++; $display("FAIL denorm_flag_clear got %b want 0", flag_denorm); end
    endtask

    task automatic test_zero();
        int lat;
        run_op(25'h0000000, 8'd100, 1'b1, lat);
        n_vec++; if (result !== 32'h80000000) begin n_err++; $display("FAIL zero_result got %h want 80000000", result); end
        n_vec++; if ({flag_zero, flag_ovf, flag_denorm} !== 3'b100) begin n_err++;
            $display("FAIL zero_flags got %b want 100", {flag_zero, flag_ovf, flag_denorm}); end
        consume();
    endtask

    task automatic test_ovf();
        int lat;
        run_op(25'h1FFFFFE, 8'd254, 1'b0, lat);
        n_vec++; if (result !== 32'h7F800000) begin n_err++; $display("FAIL ovf_result got %h want 7f800000", result); end
        n_vec++; if ({flag_zero, flag_ovf, flag_denorm} !== 3'b010) begin n_err++;
            $display("FAIL ovf_flags got %b want 010", {flag_zero, flag_ovf, flag_denorm}); end
        consume();
    endtask

    task automatic test_round();
        int lat;
        logic [31:0] exp_r;
`ifdef FP_NORM_ROUND_NEAREST_EN
        exp_r = 32'h40000002;
`else
        exp_r = 32'h40000001;
`endif
        run_op(25'h1000003, 8'd127, 1'b0, lat);
        n_vec++; if (result !== exp_r) begin n_err++; $display("FAIL round_result got %h want %h", result, exp_r); end
        consume();
    endtask

    task automatic test_reset_mid();
        int seen;
        @(posedge clk); #1;
        sum = 25'h0000001; exp_in = 8'd127; sign_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL midrst_no_emit got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(25'h0C00000, 8'd128, 1'b1, lat);
        n_vec++; if (result !== 32'hC0400000) begin n_err++; $display("FAIL b2b_first got %h want c0400000", result); end
        consume();
        run_op(25'h0400000, 8'd127, 1'b0, lat);
        n_vec++; if (result !== 32'h3F000000) begin n_err++; $display("FAIL b2b_second got %h want 3f000000", result); end
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL b2b_latency got %0d want 3", lat); end
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unity();
        test_carry_hold();
        test_worst();
        test_denorm();
        test_zero();
        test_ovf();
        test_round();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
